// File: rtl/data_receive_if.sv
// Serial-receive bundle: the line going in, and the reassembled word plus status pulses coming out.
// state_dbg mirrors the receiver FSM state so it can be observed without probing inside the block.
interface data_receive_if #(
    parameter int W = 56
);
    logic         uartRx;
    logic [W-1:0] dataOut;
    logic         dataRxDone;
    logic         frameErr;
    logic [1:0]   state_dbg;

    modport master (
        output uartRx,
        input  dataOut, dataRxDone, frameErr, state_dbg
    );

    modport slave (
        input  uartRx,
        output dataOut, dataRxDone, frameErr, state_dbg
    );
endinterface

// File: rtl/data_receive.sv
// 8N1 UART receiver that packs BYTENUM consecutive bytes (first byte in the LSBs) into one word,
// discarding a partial word on a framing error or when the line idles too long between bytes.
module data_receive #(
    parameter int CLKFREQ     = 100_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int BYTENUM     = 7,
    parameter int TIMEOUTBITS = 20
) (
    input  logic          clk,
    input  logic          reset,
    data_receive_if.slave rx
);
    localparam int BAUDDIV = CLKFREQ / BAUDRATE;
    localparam int TMO     = TIMEOUTBITS * BAUDDIV;
    localparam int W       = 8 * BYTENUM;
    localparam int TW      = $clog2(BAUDDIV);
    localparam int BW      = (BYTENUM > 1) ? $clog2(BYTENUM) : 1;
    localparam int OW      = $clog2(TMO);

    // Timer reloads are one short: the action happens on the edge after the timer reaches zero.
    localparam logic [TW-1:0] FULL_LD   = TW'(BAUDDIV - 1);
    localparam logic [TW-1:0] HALF_LD   = TW'(BAUDDIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTENUM - 1);
    localparam logic [OW-1:0] TMO_LAST  = OW'(TMO - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [OW-1:0] tmo_q, tmo_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          expire;

    assign rx_s   = sync_q[1];
    assign expire = (tmr_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            tmo_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx.uartRx};
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = expire ? tmr_q : tmr_q - TW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        tmo_d   = '0;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tmr_d   = HALF_LD;
                end else if (bcnt_q != '0) begin
                    // Inter-byte gap too long: drop the partial word silently.
                    if (tmo_q == TMO_LAST) begin
                        bcnt_d = '0;
                        asm_d  = '0;
                    end else begin
                        tmo_d = tmo_q + OW'(1);
                    end
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                        tmr_d   = FULL_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    tmr_d = FULL_LD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Back to IDLE at the stop-bit mid-point so an immediately following start bit is seen.
                if (expire) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        if (bcnt_q == LAST_BYTE) begin
                            dout_d               = asm_q;
                            dout_d[8*bcnt_q +: 8] = sh_q;
                            done_d               = 1'b1;
                            bcnt_d               = '0;
                            asm_d                = '0;
                        end else begin
                            asm_d[8*bcnt_q +: 8] = sh_q;
                            bcnt_d               = bcnt_q + BW'(1);
                        end
                    end else begin
                        err_d  = 1'b1;
                        bcnt_d = '0;
                        asm_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.dataOut    = dout_q;
    assign rx.dataRxDone = done_q;
    assign rx.frameErr   = err_q;
    assign rx.state_dbg  = state_q;
endmodule

// File: tb/tb_data_receive.sv
// Bench for data_receive: drives serial frames and checks reassembled words against a byte-queue model.
module tb_data_receive;
  localparam int CLKF = 3_200_000;
  localparam int BAUD = 100_000;
  localparam int BN   = 7;
  localparam int TB   = 20;
  localparam int BD   = CLKF / BAUD;
  localparam int W    = 8 * BN;

  logic clk;
  logic reset;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  data_receive_if #(.W(W)) bus();

  data_receive #(
    .CLKFREQ(CLKF), .BAUDRATE(BAUD), .BYTENUM(BN), .TIMEOUTBITS(TB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // reference model: bytes of the word in progress, expected words, pending frame errors
  logic [7:0]   mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_last = '0;
  int done_exp = 0;
  int err_exp = 0;
  int err_pend = 0;
  int done_seen = 0;
  int err_seen = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [W-1:0] word;
    mq.push_back(b);
    if (mq.size() == BN) begin
      word = '0;
      for (int k = 0; k < BN; k++) word[8*k +: 8] = mq[k];
      exp_q.push_back(word);
      model_last = word;
      done_exp++;
      mq.delete();
    end
  endtask

  // driver tasks (line changes on falling clock edges)
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    bus.uartRx = 1'b0;
    wait_cycles(BD);
    for (int i = 0; i < 8; i++) begin
      bus.uartRx = b[i];
      wait_cycles(BD);
    end
    if (good_stop) begin
      model_byte(b);
      bus.uartRx = 1'b1;
      wait_cycles(BD);
    end else begin
      mq.delete();
      err_exp++;
      err_pend++;
      bus.uartRx = 1'b0;
      wait_cycles(20);
      bus.uartRx = 1'b1;
      wait_cycles(2 * BD - 20);
    end
  endtask

  task automatic send_bytes(input logic [W-1:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bytes(w, 0, BN - 1);
  endtask

  // The receiver is idle from mid stop bit, so the real gap is about half a bit longer.
  task automatic idle_bits(input int n);
    bus.uartRx = 1'b1;
    wait_cycles(n * BD);
    if (n * BD + BD / 2 >= TB * BD) mq.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dataRxDone) begin
        check("done_one_cycle", prev_done, 0);
        check("done_err_excl", bus.frameErr, 0);
        done_seen++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("word", bus.dataOut, exp_q.pop_front());
      end
      if (bus.frameErr) begin
        err_seen++;
        check("ferr_expected", err_pend != 0, 1);
        if (err_pend > 0) err_pend--;
      end
    end
    prev_done = bus.dataRxDone;
  end

  initial begin
    logic [W-1:0] w;

    reset = 1'b1;
    bus.uartRx = 1'b1;
    wait_cycles(3);
    check("rst_dout", bus.dataOut, 0);
    check("rst_done", bus.dataRxDone, 0);
    check("rst_ferr", bus.frameErr, 0);
    check("rst_state", bus.state_dbg, 0);
    reset = 1'b0;
    idle_bits(2);

    // loopback-style word
    send_word(56'h00000000004E20);
    idle_bits(2);
    check("loopback_dout", bus.dataOut, 56'h00000000004E20);

    // glitch shorter than half a bit: START then back to IDLE
    bus.uartRx = 1'b0;
    wait_cycles(6);
    bus.uartRx = 1'b1;
    wait_cycles(4);
    check("glitch_start", bus.state_dbg, 1);
    wait_cycles(2 * BD);
    check("glitch_idle", bus.state_dbg, 0);
    check("glitch_hold", bus.dataOut, model_last);
    send_word(56'h0123456789ABCD);
    idle_bits(1);

    // framing error on the third byte
    w = 56'hDEADBEEFCAFE01;
    send_bytes(w, 0, 1);
    send_byte(w[23:16], 1'b0);
    idle_bits(1);
    check("ferr_hold", bus.dataOut, model_last);
    send_word(56'h13579BDF02468A);
    idle_bits(1);

    // gap under the timeout keeps the partial word
    w = 56'hA1B2C3D4E5F607;
    send_bytes(w, 0, 3);
    idle_bits(10);
    send_bytes(w, 4, BN - 1);
    idle_bits(1);

    // gap over the timeout drops it
    send_bytes(56'h55443322110099, 0, 3);
    idle_bits(30);
    check("timeout_hold", bus.dataOut, model_last);
    send_word(56'hFFEEDDCCBBAA99);
    idle_bits(1);
    check("timeout_next", bus.dataOut, 56'hFFEEDDCCBBAA99);

    // reset in the middle of data bit 4 of the third byte
    send_bytes(56'h77665544332211, 0, 1);
    bus.uartRx = 1'b0;
    wait_cycles(BD);
    for (int i = 0; i < 4; i++) begin
      bus.uartRx = i[0];
      wait_cycles(BD);
    end
    bus.uartRx = 1'b1;
    wait_cycles(BD / 2);
    reset = 1'b1;
    #1;
    check("midrst_dout", bus.dataOut, 0);
    check("midrst_done", bus.dataRxDone, 0);
    check("midrst_ferr", bus.frameErr, 0);
    check("midrst_state", bus.state_dbg, 0);
    wait_cycles(2);
    reset = 1'b0;
    mq.delete();
    model_last = '0;
    idle_bits(3);
    send_word(56'h11);
    idle_bits(1);
    check("after_rst_dout", bus.dataOut, 56'h11);

    // back-to-back words with no idle gap
    send_word(56'h0F1E2D3C4B5A69);
    send_word(56'h8796A5B4C3D2E1);
    idle_bits(1);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 70 * BD);

    // random words and random short gaps
    for (int i = 0; i < 5; i++) begin
      w = W'({$urandom(), $urandom()});
      send_word(w);
      idle_bits($urandom_range(0, 3));
    end

    idle_bits(3);
    check("done_count", done_seen, done_exp);
    check("ferr_count", err_seen, err_exp);
    check("exp_q_empty", exp_q.size(), 0);
    check("final_dout", bus.dataOut, model_last);
    check("final_state", bus.state_dbg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
